instruction_queue: RTL

//  Fetch front end feeding the decoder. Owns the fetch PC and issues one word request at a time to the ICache.

---
 rtl/instruction_queue_pkg.sv | 17 +
 rtl/instruction_queue.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/instruction_queue_pkg.sv
// Shared types and decode helpers for the fetch front end.
package instruction_queue_pkg;

    typedef enum logic [1:0] {
        IQ_IDLE = 2'd0,
        IQ_WAIT = 2'd1,
        IQ_DROP = 2'd2
    } iq_state_e;

    localparam logic [6:0] JALOP = 7'b1101111;

    // J-type immediate from inst[31:12]: sign-extended, bit0 forced to 0
    function automatic logic [31:0] j_imm(input logic [19:0] hi);
        return {{12{hi[19]}}, hi[7:0], hi[8], hi[18:9], 1'b0};
    endfunction

endpackage

// File: rtl/instruction_queue.sv
// Fetch front end: owns the fetch PC, one outstanding ICache request,
// and a circular FIFO of {inst, PC} pairs presented to the decoder.
module instruction_queue
    import instruction_queue_pkg::*;
#(
    parameter int IQ_SIZE_LOG = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        IC_flag,
    output logic [31:0] IC_PC,
    input  logic        IC_done,
    input  logic [31:0] IC_inst,
    output logic        IQ_flag,
    output logic [31:0] IQ_inst,
    output logic [31:0] IQ_PC,
    input  logic        Dec_flag,
    input  logic        ROB_clear,
    input  logic [31:0] ROB_PC
);

    localparam int DEPTH = 1 << IQ_SIZE_LOG;
    localparam int CW    = IQ_SIZE_LOG + 1;

    localparam logic [CW-1:0]          CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0]          CNT_ONE  = CW'(1);
    localparam logic [IQ_SIZE_LOG-1:0] PTR_ONE  = IQ_SIZE_LOG'(1);

    logic [31:0] inst_q [DEPTH];
    logic [31:0] pc_q   [DEPTH];

    logic [IQ_SIZE_LOG-1:0] head_q, head_d;
    logic [IQ_SIZE_LOG-1:0] tail_q, tail_d;
    logic [CW-1:0]          count_q, count_d;

    iq_state_e   state_q;
    logic        ic_flag_q;
    logic [31:0] ic_pc_q;
    logic [31:0] fetch_pc_q;

    logic        pop;
    logic        push;
    logic [31:0] next_pc;

    assign IQ_flag = (count_q != '0) && !ROB_clear;
    assign IQ_inst = inst_q[head_q];
    assign IQ_PC   = pc_q[head_q];
    assign IC_flag = ic_flag_q;
    assign IC_PC   = ic_pc_q;

    assign pop  = IQ_flag && Dec_flag;
    assign push = (state_q == IQ_WAIT) && IC_done && !ROB_clear;

    // Static prediction: only JAL redirects, everything else falls through
    assign next_pc = fetch_pc_q
                   + ((IC_inst[6:0] == JALOP) ? j_imm(IC_inst[31:12])
                                              : 32'd4);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (ROB_clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop) begin
                head_d = head_q + PTR_ONE;
            end
            if (push) begin
                tail_d = tail_q + PTR_ONE;
            end
            unique case (1'b1)
                push && !pop: count_d = count_q + CNT_ONE;
                pop && !push: count_d = count_q - CNT_ONE;
                default:      count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (rdy_in) begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && push) begin
            inst_q[tail_q] <= IC_inst;
            pc_q[tail_q]   <= fetch_pc_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IQ_IDLE;
            ic_flag_q  <= 1'b0;
            ic_pc_q    <= '0;
            fetch_pc_q <= '0;
        end else if (!rdy_in) begin
            // Keep the request a single-cycle pulse across a stall
            ic_flag_q <= 1'b0;
        end else begin
            ic_flag_q <= 1'b0;
            if (ROB_clear) begin
                fetch_pc_q <= ROB_PC;
                if (state_q != IQ_IDLE && IC_done) begin
                    state_q <= IQ_IDLE;
                end else if (state_q == IQ_WAIT) begin
                    state_q <= IQ_DROP;
                end
            end else begin
                unique case (state_q)
                    IQ_IDLE: begin
                        if (count_q < CNT_FULL) begin
                            ic_flag_q <= 1'b1;
                            ic_pc_q   <= fetch_pc_q;
                            state_q   <= IQ_WAIT;
                        end
                    end
                    IQ_WAIT: begin
                        if (IC_done) begin
                            fetch_pc_q <= next_pc;
                            state_q    <= IQ_IDLE;
                        end
                    end
                    IQ_DROP: begin
                        if (IC_done) begin
                            state_q <= IQ_IDLE;
                        end
                    end
                    default: state_q <= IQ_IDLE;
                endcase
            end
        end
    end

endmodule
